hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Read-side companion to the register file: tracks in-flight destination registers through the EX, MEM and WB stages of the 5-stage pipeline.
- For the instruction in ID, decides whether register-file read data is stale. It raises a load-use stall or issues registered forwarding selects to the EX operand muxes.
- The register file writes on the falling edge, so a WB-stage writer is readable in the same cycle and never needs forwarding.

Parameters:
REG_ADDR_W, 5, register index width (32 registers; index 0 hardwired zero)
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_ADDR_W  first source register index
id_rt  in  REG_ADDR_W  second source register index
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_wr_en  in  1  instruction writes a register
id_rd  in  REG_ADDR_W  destination register index
id_is_load  in  1  instruction is a load (result available after MEM)
flush  in  1  kill instruction in ID (taken branch/jump)
stall  out  1  combinational: hold PC and IF/ID, bubble into EX
ex_fwd_a  out  2  registered operand-A select for instruction now in EX
ex_fwd_b  out  2  registered operand-B select for instruction now in EX
stall_count  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Synchronous reset, active-high, on clk rising edge.
- Internal slots EX, MEM, WB. Each slot holds: valid, wr_en, rd, is_load. EX also holds fwd_a and fwd_b.
- A slot "writes r" when valid & wr_en & rd==r & r!=0. Register 0 never creates a hazard or a forward.
- Source hazard for rs requires id_valid & id_uses_rs; same rule for rt with id_uses_rt.
- stall = !flush & id_valid & EX slot is a load that writes a used source (rs or rt). Flush overrides stall.
- Forward select, computed per source in ID:
  - 2'b10 if EX slot writes it. Data comes from EX/MEM next cycle; EX takes priority as the most recent writer.
  - else 2'b01 if MEM slot writes it. Data comes from MEM/WB next cycle.
  - else 2'b00, register file.
  - Source not used -> 2'b00.
- Every rising edge when rst=0:
  - WB <= MEM; MEM <= EX.
  - If stall | flush | !id_valid: EX <= bubble (valid=0, fwd=00).
  - Else EX <= ID fields plus computed fwd_a and fwd_b.
- ex_fwd_a = EX.fwd_a, ex_fwd_b = EX.fwd_b. These are 00 whenever EX is a bubble.
- Latency: selects appear 1 cycle after the instruction leaves ID.
- Load-use costs exactly one bubble. On the retry the load is in MEM, so the instruction's select becomes 01.
- stall_count increments on every cycle with stall=1 and saturates at all-ones. It never wraps.
- Reset values: all slots invalid, ex_fwd_a=ex_fwd_b=00, stall_count=0. stall=0 during reset because the EX slot is invalid.
- Reset asserted mid-operation discards all tracked writers. The first instruction after reset sees no hazards.
- rs==rt with a hazard: both selects are set identically.
- The WB slot is tracked for observability and debug only. It never affects stall or the selects.

Test Plan:
- Load-use: lw r2 into ID, next cycle add r3,r2,r1 -> stall=1 for exactly 1 cycle and a bubble in EX. The add then enters EX with ex_fwd_a=01, ex_fwd_b=00; stall_count=1.
- Back-to-back ALU: add r1,r4,r5 then sub r6,r1,r1 -> no stall; sub in EX shows ex_fwd_a=10, ex_fwd_b=10.
- Double writer: add r7 then or r7 then and r8,r7,r0 -> and in EX shows ex_fwd_a=10 (most recent wins), ex_fwd_b=00.
- Zero register: lw r0 then add r2,r0,r0 -> stall=0, both selects 00.
- Flush during load-use: lw r2, then add using r2 with flush=1 -> stall=0, EX bubble (selects 00), stall_count unchanged.
- Reset and saturation:
  - rst=1 with a load in EX -> next cycle all selects 00, stall_count=0, and a following dependent instruction sees no stall.
  - With STALL_CNT_W=2, five load-use stalls -> stall_count holds 3.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Interface between the ID stage and the hazard scoreboard.
// The ID stage (master) presents the decoded instruction and the flush request.
// The scoreboard (slave) returns the load-use stall, the EX forwarding selects,
// the stall-cycle counter and the WB slot contents for debug visibility.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    // Decoded instruction currently in ID
    logic                    id_valid;
    logic [REG_ADDR_W-1:0]   id_rs;
    logic [REG_ADDR_W-1:0]   id_rt;
    logic                    id_uses_rs;
    logic                    id_uses_rt;
    logic                    id_wr_en;
    logic [REG_ADDR_W-1:0]   id_rd;
    logic                    id_is_load;
    logic                    flush;

    // Hazard decisions
    logic                    stall;
    logic [1:0]              ex_fwd_a;
    logic [1:0]              ex_fwd_b;
    logic [STALL_CNT_W-1:0]  stall_count;

    // WB slot contents, for observability only
    logic                    wb_valid;
    logic                    wb_wr_en;
    logic [REG_ADDR_W-1:0]   wb_rd;
    logic                    wb_is_load;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_wr_en, id_rd, id_is_load, flush,
        input  stall, ex_fwd_a, ex_fwd_b, stall_count,
               wb_valid, wb_wr_en, wb_rd, wb_is_load
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_wr_en, id_rd, id_is_load, flush,
        output stall, ex_fwd_a, ex_fwd_b, stall_count,
               wb_valid, wb_wr_en, wb_rd, wb_is_load
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage pipeline.
// Tracks the destination registers of the instructions in EX, MEM and WB and,
// for the instruction in ID, either raises a one-cycle load-use stall or
// computes the operand forwarding selects that are registered into EX.
// A WB writer never needs forwarding: the register file writes on the falling
// edge, so its data is already readable in ID. The WB slot is kept for debug.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);

    // Operand mux selects for the EX stage
    localparam logic [1:0] FWD_REGFILE = 2'b00;  // register-file read data
    localparam logic [1:0] FWD_MEMWB   = 2'b01;  // result held in MEM/WB
    localparam logic [1:0] FWD_EXMEM   = 2'b10;  // result held in EX/MEM

    // EX slot (p0)
    logic                    vld_p0;
    logic                    wr_p0;
    logic [REG_ADDR_W-1:0]   rd_p0;
    logic                    ld_p0;
    logic [1:0]              fwd_a_p0;
    logic [1:0]              fwd_b_p0;

    // MEM slot (p1)
    logic                    vld_p1;
    logic                    wr_p1;
    logic [REG_ADDR_W-1:0]   rd_p1;
    logic                    ld_p1;

    // WB slot (p2)
    logic                    vld_p2;
    logic                    wr_p2;
    logic [REG_ADDR_W-1:0]   rd_p2;
    logic                    ld_p2;

    logic [STALL_CNT_W-1:0]  stall_cnt;

    // ID-stage decode of hazards
    logic                    rs_used;
    logic                    rt_used;
    logic                    ex_hit_rs;
    logic                    ex_hit_rt;
    logic                    mem_hit_rs;
    logic                    mem_hit_rt;
    logic                    load_use;
    logic                    stall_id;
    logic                    issue;
    logic [1:0]              fwd_a_id;
    logic [1:0]              fwd_b_id;

    // A slot produces register r only if it is live, writes, and r is not r0.
    function automatic logic slot_writes(
        input logic                  vld,
        input logic                  wr,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] r
    );
        return vld & wr & (rd == r) & (r != '0);
    endfunction

    // The youngest writer wins: EX is more recent than MEM.
    function automatic logic [1:0] fwd_select(
        input logic used,
        input logic ex_hit,
        input logic mem_hit
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (used) begin
            if (ex_hit) begin
                sel = FWD_EXMEM;
            end else if (mem_hit) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

    // Counter saturates at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(
        input logic [STALL_CNT_W-1:0] cnt
    );
        return (&cnt) ? cnt : cnt + STALL_CNT_W'(1);
    endfunction

    // Compare ID sources against EX/MEM writers; decide stall, issue and selects
    always_comb begin
        rs_used    = bus.id_valid & bus.id_uses_rs;
        rt_used    = bus.id_valid & bus.id_uses_rt;
        ex_hit_rs  = slot_writes(vld_p0, wr_p0, rd_p0, bus.id_rs);
        ex_hit_rt  = slot_writes(vld_p0, wr_p0, rd_p0, bus.id_rt);
        mem_hit_rs = slot_writes(vld_p1, wr_p1, rd_p1, bus.id_rs);
        mem_hit_rt = slot_writes(vld_p1, wr_p1, rd_p1, bus.id_rt);
        // A load in EX has no data until after MEM, so a dependent reader waits once
        load_use   = ld_p0 & ((rs_used & ex_hit_rs) | (rt_used & ex_hit_rt));
        stall_id   = ~bus.flush & bus.id_valid & load_use;
        issue      = bus.id_valid & ~bus.flush & ~stall_id;
        fwd_a_id   = fwd_select(rs_used, ex_hit_rs, mem_hit_rs);
        fwd_b_id   = fwd_select(rt_used, ex_hit_rt, mem_hit_rt);
    end

    // Control state: slot valids, EX selects and the stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            fwd_a_p0  <= FWD_REGFILE;
            fwd_b_p0  <= FWD_REGFILE;
            stall_cnt <= '0;
        end else begin
            vld_p2 <= vld_p1;
            vld_p1 <= vld_p0;
            vld_p0 <= issue;
            // A bubble in EX always carries register-file selects
            fwd_a_p0 <= issue ? fwd_a_id : FWD_REGFILE;
            fwd_b_p0 <= issue ? fwd_b_id : FWD_REGFILE;
            if (stall_id) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // Writer fields ride along unreset; they only matter when the slot is valid
    always_ff @(posedge clk) begin
        wr_p0 <= bus.id_wr_en;
        rd_p0 <= bus.id_rd;
        ld_p0 <= bus.id_is_load;
        wr_p1 <= wr_p0;
        rd_p1 <= rd_p0;
        ld_p1 <= ld_p0;
        wr_p2 <= wr_p1;
        rd_p2 <= rd_p1;
        ld_p2 <= ld_p1;
    end

    assign bus.stall       = stall_id;
    assign bus.ex_fwd_a    = fwd_a_p0;
    assign bus.ex_fwd_b    = fwd_b_p0;
    assign bus.stall_count = stall_cnt;
    assign bus.wb_valid    = vld_p2;
    assign bus.wb_wr_en    = wr_p2;
    assign bus.wb_rd       = rd_p2;
    assign bus.wb_is_load  = ld_p2;

endmodule
